memoria_sync: RTL and testbench
===============================

Name: memoria_sync

Overview:
- Parametrised single-port synchronous word memory; the next generation of the processor's instruction/data RAM.
- Replaces the split write/read clock edges with one clock and a valid/ready request channel.
- Adds:
  - a fixed-latency read response pipeline;
  - byte-lane write enables;
  - an out-of-range error response;
  - a post-reset clear sequencer that zeroes the array before accepting traffic.

Parameters:
- DATA_W, 32, word width in bits; must be a multiple of 8.
- ADDR_W, 10, address width in words.
- DEPTH, 128, number of implemented words; DEPTH <= 2**ADDR_W.
- RD_LAT, 1, cycles from request acceptance to response, legal 1..3.
- CLEAR_ON_RESET, 1, 1 = zero the array after reset, 0 = skip the clear.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- req_be  in  DATA_W/8  byte enables; bit i gates bits [8i+7:8i].
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
- rsp_err  out  1  request address was >= DEPTH; valid only with rsp_valid.
- busy  out  1  clear sequence in progress.

Behaviour:
- Reset (rst_n=0, async):
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - busy=CLEAR_ON_RESET.
  - Response pipeline flushed; clear counter=0.
  - Array contents are not reset by rst_n.
- FSM states are CLEAR and RUN:
  - After reset, the FSM enters CLEAR if CLEAR_ON_RESET=1, otherwise RUN.
  - In CLEAR, the block writes 0 to address clr_cnt each cycle and increments clr_cnt.
  - When clr_cnt==DEPTH-1 is written, the FSM moves to RUN. CLEAR lasts exactly DEPTH cycles.
  - In CLEAR: busy=1, req_ready=0, and requests are ignored.
  - In RUN: busy=0, req_ready=1 every cycle (no stalls), and the FSM stays in RUN until reset.
- Acceptance: a request is accepted on a rising edge where req_valid && req_ready.
- Writes (addr < DEPTH):
  - Each byte lane i with req_be[i]=1 is updated at the accept edge; other lanes keep their old value.
  - req_be=0 is a legal no-op write that still produces a response.
- Reads (addr < DEPTH): return the array contents as of the accept edge.
- Response timing:
  - Every accepted request, read or write, produces exactly one rsp_valid pulse.
  - The pulse is RD_LAT cycles after the accept edge. With RD_LAT=1, rsp_valid is high in the cycle after acceptance.
  - Responses come back in order.
  - Full throughput: one request per cycle gives one response per cycle once the pipeline is full.
  - There is no response backpressure; the consumer must sink every pulse.
- Read-after-write:
  - A read accepted the cycle after a write to the same address returns the new data.
  - Reads and writes are serialised on one port, so no same-cycle conflict exists.
- Out of range (req_addr >= DEPTH):
  - Writes are suppressed.
  - The response carries rsp_err=1 and rsp_rdata=0.
- While rsp_valid=0:
  - rsp_rdata and rsp_err hold 0.
  - The verifier checks this; the implementation drives zeros, not stale data.
- Reset mid-operation:
  - Responses in flight are discarded with no rsp_valid.
  - A reset during CLEAR restarts the clear at address 0.
  - A write accepted at the same edge reset is asserted is lost.
- Widths: the pipeline carries rdata, err, and a valid bit per stage; the clear counter is $clog2(DEPTH) bits wide.

Decomposition:
- Shared package memoria_pkg holds:
  - the state enum {ST_CLEAR, ST_RUN};
  - the RD_LAT legality constants RD_LAT_MIN=1 and RD_LAT_MAX=3;
  - a function that merges byte-enabled write data.
- Natural sub-module: memoria_rsp_pipe, a parametrised RD_LAT-deep shift register carrying {valid, err, rdata} with async reset of the valid bits.
- The array and the FSM stay in the top module.

Test Plan:
- Reset, CLEAR_ON_RESET=1, DEPTH=128 -> busy=1 and req_ready=0 for exactly 128 cycles; then a read of address 5 returns 0x00000000 with rsp_err=0.
- Sequence write 0x11223344 to address 3 with be=4'b1111, then write 0xAABBCCDD with be=4'b0101, then read address 3 -> rsp_rdata=0x11BB33DD.
- RD_LAT=3, reads of addresses 0..7 issued back-to-back after preloading data=addr*4 -> 8 consecutive rsp_valid pulses starting 3 cycles after the first accept, in order: 0, 4, 8, ..., 28.
- Write 0xDEADBEEF to address 200 with DEPTH=128, then read address 200 -> both responses have rsp_err=1 and rsp_rdata=0; addresses 0..127 are unchanged.
- Assert rst_n=0 for one cycle at cycle 40 of CLEAR -> busy stays 1 for a further 128 full cycles after release.
- Assert rst_n=0 with 2 reads in flight (RD_LAT=2) -> no rsp_valid pulse after release; array data written earlier is intact when CLEAR_ON_RESET=0.

Source files
------------

// File: rtl/memoria_pkg.sv
// Shared types and helpers for the memoria_sync word memory.
package memoria_pkg;

   typedef enum logic {
      ST_CLEAR,
      ST_RUN
   } state_t;

   localparam int RD_LAT_MIN = 1;
   localparam int RD_LAT_MAX = 3;

   // Widest word the byte-merge helper handles; callers zero-extend and truncate.
   localparam int MERGE_W    = 256;
   localparam int MERGE_BE_W = MERGE_W / 8;

   function automatic logic [MERGE_W-1:0] merge_bytes(
      input logic [MERGE_W-1:0]    old_data,
      input logic [MERGE_W-1:0]    new_data,
      input logic [MERGE_BE_W-1:0] be
   );
      logic [MERGE_W-1:0] res;
      res = old_data;
      for (int i = 0; i < MERGE_BE_W; i++) begin
         if (be[i]) begin
            res[8*i +: 8] = new_data[8*i +: 8];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/memoria_rsp_pipe.sv
// Fixed-latency response shift register carrying {valid, err, rdata}.
// Idle stages hold zeros so the output never shows stale data.
module memoria_rsp_pipe #(
   parameter int DATA_W = 32,
   parameter int STAGES = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic              in_err,
   input  logic [DATA_W-1:0] in_rdata,
   output logic              out_valid,
   output logic              out_err,
   output logic [DATA_W-1:0] out_rdata
);

   logic [STAGES-1:0] vld;
   logic [STAGES-1:0] err;
   logic [DATA_W-1:0] dat [STAGES];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld <= '0;
         err <= '0;
         for (int i = 0; i < STAGES; i++) begin
            dat[i] <= '0;
         end
      end else begin
         vld[0] <= in_valid;
         err[0] <= in_valid & in_err;
         dat[0] <= in_valid ? in_rdata : '0;
         for (int i = 1; i < STAGES; i++) begin
            vld[i] <= vld[i-1];
            err[i] <= err[i-1];
            dat[i] <= dat[i-1];
         end
      end
   end

   assign out_valid = vld[STAGES-1];
   assign out_err   = err[STAGES-1];
   assign out_rdata = dat[STAGES-1];

endmodule

// File: rtl/memoria_sync.sv
// Single-port synchronous word memory with valid/ready requests, byte-lane
// writes, fixed-latency in-order responses and a post-reset clear sequencer.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_CLEAR | writing zero to word clr_cnt each cycle; requests ignored
//   ST_RUN   | accepting one request per cycle until the next reset
module memoria_sync
   import memoria_pkg::*;
#(
   parameter int DATA_W         = 32,
   parameter int ADDR_W         = 10,
   parameter int DEPTH          = 128,
   parameter int RD_LAT         = 1,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_write,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [DATA_W/8-1:0] req_be,
   output logic                rsp_valid,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_err,
   output logic                busy
);

   localparam int               IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]  DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

   if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX || (DATA_W % 8) != 0 ||
       DATA_W > MERGE_W || DEPTH < 1 || DEPTH > (2 ** ADDR_W)) begin : g_bad_param
      $error("memoria_sync: illegal parameter combination");
   end

   state_t            state;
   logic [IDX_W-1:0]  clr_cnt;
   logic [DATA_W-1:0] mem [DEPTH];

   logic              accept;
   logic              in_range;
   logic [IDX_W-1:0]  idx;
   logic [DATA_W-1:0] rd_word;
   logic [DATA_W-1:0] merged;
   logic              mem_we;
   logic [IDX_W-1:0]  mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] pipe_rdata;

   assign accept   = req_valid && req_ready;
   assign in_range = {1'b0, req_addr} < DEPTH_LIM;
   assign idx      = IDX_W'(req_addr);
   assign rd_word  = in_range ? mem[idx] : '0;
   assign merged   = DATA_W'(merge_bytes(MERGE_W'(rd_word), MERGE_W'(req_wdata),
                                         MERGE_BE_W'(req_be)));

   // The clear sequencer owns the single write port while it runs.
   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = idx;
      mem_wdata = merged;
      if (state == ST_CLEAR) begin
         mem_we    = 1'b1;
         mem_addr  = clr_cnt;
         mem_wdata = '0;
      end else if (accept && req_write && in_range) begin
         mem_we = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_addr] <= mem_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
         clr_cnt   <= '0;
         busy      <= (CLEAR_ON_RESET != 0);
         req_ready <= 1'b0;
      end else begin
         case (state)
            ST_CLEAR: begin
               if (clr_cnt == LAST_IDX) begin
                  state     <= ST_RUN;
                  clr_cnt   <= '0;
                  busy      <= 1'b0;
                  req_ready <= 1'b1;
               end else begin
                  clr_cnt <= clr_cnt + 1'b1;
               end
            end
            ST_RUN: begin
               busy      <= 1'b0;
               req_ready <= 1'b1;
            end
            default: begin
               state <= ST_RUN;
            end
         endcase
      end
   end

   assign pipe_rdata = (!req_write && in_range) ? rd_word : '0;

   memoria_rsp_pipe #(
      .DATA_W (DATA_W),
      .STAGES (RD_LAT)
   ) u_rsp_pipe (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (accept),
      .in_err    (!in_range),
      .in_rdata  (pipe_rdata),
      .out_valid (rsp_valid),
      .out_err   (rsp_err),
      .out_rdata (rsp_rdata)
   );

endmodule

// File: tb/tb_memoria_sync.sv
// Bench for memoria_sync: three configurations share one request bus and are
// each compared against a word-array reference model with expected-response queues.
module tb_memoria_sync;

   localparam int N     = 3;
   localparam int DEPTH = 128;
   localparam int LAT [N] = '{1, 3, 2};
   localparam int CLR [N] = '{1, 1, 0};

   typedef struct {
      int          due;
      logic [31:0] data;
      logic [31:0] mask;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_write = 1'b0;
   logic [9:0]  req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [3:0]  req_be = '0;

   logic        rdy [N];
   logic        rv  [N];
   logic        er  [N];
   logic        bz  [N];
   logic [31:0] rd  [N];

   memoria_sync #(.DATA_W(32), .ADDR_W(10), .DEPTH(DEPTH), .RD_LAT(1), .CLEAR_ON_RESET(1)) u_lat1 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy[0]), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rv[0]),
      .rsp_rdata(rd[0]), .rsp_err(er[0]), .busy(bz[0]));

   memoria_sync #(.DATA_W(32), .ADDR_W(10), .DEPTH(DEPTH), .RD_LAT(3), .CLEAR_ON_RESET(1)) u_lat3 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy[1]), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rv[1]),
      .rsp_rdata(rd[1]), .rsp_err(er[1]), .busy(bz[1]));

   memoria_sync #(.DATA_W(32), .ADDR_W(10), .DEPTH(DEPTH), .RD_LAT(2), .CLEAR_ON_RESET(0)) u_lat2 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy[2]), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rv[2]),
      .rsp_rdata(rd[2]), .rsp_err(er[2]), .busy(bz[2]));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [31:0] mm [N][DEPTH];
   logic [3:0]  kn [N][DEPTH];
   exp_t        q  [N][$];
   int          n_checks = 0;
   int          n_pass = 0;
   bit          in_reset = 1'b0;
   int          rel_cyc = 0;
   logic [31:0] last_rd  [N];
   logic        last_err [N];
   int          cap_cyc [$];
   logic [31:0] cap_dat [$];
   int          pulse_cnt = 0;

   function automatic bit ready_exp(input int k);
      if (in_reset) return 1'b0;
      if (CLR[k] != 0) return (cyc - rel_cyc) >= DEPTH;
      return (cyc - rel_cyc) >= 1;
   endfunction

   function automatic bit busy_exp(input int k);
      if (in_reset) return CLR[k] != 0;
      return (CLR[k] != 0) && ((cyc - rel_cyc) < DEPTH);
   endfunction

   function automatic logic [31:0] lane_mask(input logic [3:0] m);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = m[i] ? 8'hFF : 8'h00;
      return r;
   endfunction

   // One clock of traffic: update the model, cross the edge, compare at the negedge.
   task automatic step(input bit v, input bit w, input logic [9:0] a,
                       input logic [31:0] d, input logic [3:0] be);
      exp_t       e;
      bit         acc [N];
      logic [6:0] ai;
      bit         ev;
      ai = a[6:0];
      req_valid = v; req_write = w; req_addr = a; req_wdata = d; req_be = be;
      for (int k = 0; k < N; k++) acc[k] = v && ready_exp(k);
      for (int k = 0; k < N; k++) begin
         if (acc[k]) begin
            e.due  = cyc + LAT[k];
            e.err  = int'(a) >= DEPTH;
            e.data = '0;
            e.mask = '1;
            if (!e.err && !w) begin
               e.data = mm[k][ai];
               e.mask = lane_mask(kn[k][ai]);
            end
            if (!e.err && w) begin
               for (int i = 0; i < 4; i++) begin
                  if (be[i]) begin
                     mm[k][ai][8*i +: 8] = d[8*i +: 8];
                     kn[k][ai][i] = 1'b1;
                  end
               end
            end
            q[k].push_back(e);
         end
      end
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      for (int k = 0; k < N; k++) begin
         ev = (q[k].size() > 0) && (q[k][0].due == cyc);
         n_checks++;
         if (ev) begin
            e = q[k].pop_front();
            if (rv[k] !== 1'b1 || er[k] !== e.err || (rd[k] & e.mask) !== (e.data & e.mask))
               $display("FAIL rsp inst%0d cyc%0d: got valid=%b err=%b data=%h, want valid=1 err=%b data=%h mask=%h",
                        k, cyc, rv[k], er[k], rd[k], e.err, e.data, e.mask);
            else n_pass++;
         end else begin
            if (rv[k] !== 1'b0 || er[k] !== 1'b0 || rd[k] !== 32'h0)
               $display("FAIL rsp_idle inst%0d cyc%0d: got valid=%b err=%b data=%h, want all zero",
                        k, cyc, rv[k], er[k], rd[k]);
            else n_pass++;
         end
         n_checks++;
         if (rdy[k] !== ready_exp(k) || bz[k] !== busy_exp(k))
            $display("FAIL ctrl inst%0d cyc%0d: got ready=%b busy=%b, want ready=%b busy=%b",
                     k, cyc, rdy[k], bz[k], ready_exp(k), busy_exp(k));
         else n_pass++;
         if (rv[k] === 1'b1) begin
            last_rd[k]  = rd[k];
            last_err[k] = er[k];
         end
      end
      if (rv[1] === 1'b1) begin
         cap_cyc.push_back(cyc);
         cap_dat.push_back(rd[1]);
      end
      if (rv[1] === 1'b1 || rv[2] === 1'b1) pulse_cnt++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 10'd0, 32'h0, 4'h0);
   endtask

   task automatic apply_reset(input int n);
      rst_n = 1'b0; in_reset = 1'b1; req_valid = 1'b0;
      for (int k = 0; k < N; k++) q[k].delete();
      for (int c = 0; c < n; c++) begin
         @(posedge clk);
         @(negedge clk);
         for (int k = 0; k < N; k++) begin
            n_checks++;
            if (rv[k] !== 1'b0 || er[k] !== 1'b0 || rd[k] !== 32'h0 || rdy[k] !== 1'b0 ||
                bz[k] !== busy_exp(k))
               $display("FAIL reset inst%0d: got valid=%b err=%b data=%h ready=%b busy=%b, want 0 0 0 0 %b",
                        k, rv[k], er[k], rd[k], rdy[k], bz[k], busy_exp(k));
            else n_pass++;
         end
      end
      rst_n = 1'b1; in_reset = 1'b0; rel_cyc = cyc;
      for (int k = 0; k < N; k++) begin
         if (CLR[k] != 0) begin
            for (int a = 0; a < DEPTH; a++) begin
               mm[k][a] = '0;
               kn[k][a] = 4'hF;
            end
         end
      end
   endtask

   // Busy samples of the RD_LAT=1 instance from release until well after the clear.
   task automatic count_clear(input string name);
      int nb;
      nb = (bz[0] === 1'b1) ? 1 : 0;
      for (int i = 0; i < DEPTH + 8; i++) begin
         idle(1);
         if (bz[0] === 1'b1) nb++;
      end
      n_checks++;
      if (nb !== DEPTH) $display("FAIL %s: got busy cycles=%0d, want %0d", name, nb, DEPTH);
      else n_pass++;
   endtask

   task automatic test_reset();
      for (int k = 0; k < N; k++) begin
         for (int a = 0; a < DEPTH; a++) kn[k][a] = 4'h0;
      end
      apply_reset(3);
   endtask

   task automatic test_clear();
      count_clear("clear_len");
      for (int k = 0; k < N; k++) last_rd[k] = '1;
      step(1'b1, 1'b0, 10'd5, 32'h0, 4'h0);
      idle(4);
      for (int k = 0; k < 2; k++) begin
         n_checks++;
         if (last_rd[k] !== 32'h0 || last_err[k] !== 1'b0)
            $display("FAIL clear_read inst%0d: got data=%h err=%b, want 00000000 0", k, last_rd[k], last_err[k]);
         else n_pass++;
      end
   endtask

   task automatic test_preload();
      for (int a = 0; a < DEPTH; a++) step(1'b1, 1'b1, 10'(a), $urandom, 4'hF);
      idle(4);
   endtask

   task automatic test_byte_lanes();
      step(1'b1, 1'b1, 10'd3, 32'h11223344, 4'b1111);
      step(1'b1, 1'b1, 10'd3, 32'hAABBCCDD, 4'b0101);
      step(1'b1, 1'b0, 10'd3, 32'h0, 4'h0);
      idle(4);
      for (int k = 0; k < N; k++) begin
         n_checks++;
         if (last_rd[k] !== 32'h11BB33DD)
            $display("FAIL byte_lanes inst%0d: got %h, want 11bb33dd", k, last_rd[k]);
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      int first_acc;
      for (int a = 0; a < 8; a++) step(1'b1, 1'b1, 10'(a), 32'(a * 4), 4'hF);
      idle(4);
      cap_cyc.delete();
      cap_dat.delete();
      first_acc = cyc + 1;
      for (int a = 0; a < 8; a++) step(1'b1, 1'b0, 10'(a), 32'h0, 4'h0);
      idle(5);
      n_checks++;
      if (cap_cyc.size() != 8 || cap_cyc[0] != first_acc + 2)
         $display("FAIL b2b_timing: got %0d pulses first at edge %0d, want 8 at edge %0d",
                  cap_cyc.size(), (cap_cyc.size() > 0) ? cap_cyc[0] : -1, first_acc + 2);
      else n_pass++;
      for (int j = 0; j < 8 && j < cap_dat.size(); j++) begin
         n_checks++;
         if (cap_dat[j] !== 32'(j * 4) || cap_cyc[j] != first_acc + 2 + j)
            $display("FAIL b2b_data[%0d]: got %h at edge %0d, want %h at edge %0d",
                     j, cap_dat[j], cap_cyc[j], 32'(j * 4), first_acc + 2 + j);
         else n_pass++;
      end
   endtask

   task automatic test_out_of_range();
      step(1'b1, 1'b1, 10'd200, 32'hDEADBEEF, 4'hF);
      idle(4);
      for (int k = 0; k < N; k++) begin
         n_checks++;
         if (last_err[k] !== 1'b1 || last_rd[k] !== 32'h0)
            $display("FAIL oor_write inst%0d: got err=%b data=%h, want 1 00000000", k, last_err[k], last_rd[k]);
         else n_pass++;
      end
      step(1'b1, 1'b0, 10'd200, 32'h0, 4'h0);
      idle(4);
      for (int k = 0; k < N; k++) begin
         n_checks++;
         if (last_err[k] !== 1'b1 || last_rd[k] !== 32'h0)
            $display("FAIL oor_read inst%0d: got err=%b data=%h, want 1 00000000", k, last_err[k], last_rd[k]);
         else n_pass++;
      end
      for (int a = 0; a < DEPTH; a++) step(1'b1, 1'b0, 10'(a), 32'h0, 4'h0);
      idle(4);
   endtask

   task automatic test_random();
      logic [9:0] a;
      for (int i = 0; i < 400; i++) begin
         a = ($urandom_range(0, 15) == 0) ? 10'($urandom_range(128, 1023)) : 10'($urandom_range(0, 127));
         step($urandom_range(0, 3) != 0, 1'($urandom), a, $urandom, 4'($urandom));
      end
      idle(4);
   endtask

   task automatic test_reset_in_clear();
      apply_reset(1);
      for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 10'($urandom_range(0, 127)), $urandom, 4'($urandom));
      apply_reset(1);
      count_clear("clear_restart");
      for (int a = 0; a < DEPTH; a += 9) step(1'b1, 1'b0, 10'(a), 32'h0, 4'h0);
      idle(4);
   endtask

   task automatic test_reset_inflight();
      step(1'b1, 1'b0, 10'd10, 32'h0, 4'h0);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 10'd11;
      @(posedge clk);
      #1 rst_n = 1'b0;
      apply_reset(1);
      pulse_cnt = 0;
      idle(10);
      n_checks++;
      if (pulse_cnt != 0) $display("FAIL flush: got %0d pulses after reset, want 0", pulse_cnt);
      else n_pass++;
      for (int a = 0; a < DEPTH; a++) step(1'b1, 1'b0, 10'(a), 32'h0, 4'h0);
      idle(140);
   endtask

   initial begin
      #2;
      test_reset();
      test_clear();
      test_preload();
      test_byte_lanes();
      test_back_to_back();
      test_out_of_range();
      test_random();
      test_reset_in_clear();
      test_reset_inflight();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
